// File: rtl/load_store_unit_if.sv
// Core/memory-side signal bundle of the load/store unit.
// The slave modport is the LSU view; the master modport is the view of
// whatever drives requests and models data_mem.
interface load_store_unit_if;
  // core request side
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  // data_mem side
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_cs_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, is_store, funct3, addr, store_data, mem_rdata,
    output busy, done, err, load_data,
    output mem_rd, mem_wr, mem_cs_n, mem_addr, mem_wdata
  );

  modport master (
    output req, is_store, funct3, addr, store_data, mem_rdata,
    input  busy, done, err, load_data,
    input  mem_rd, mem_wr, mem_cs_n, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: turns one LB/LH/LW/LBU/LHU/SB/SH/SW request into
// word-wide data_mem accesses. Sub-word stores use read-modify-write.
// All outputs come straight from flops.
module load_store_unit #(
  parameter int RD_LATENCY = 1  // cycles mem_rd is held before mem_rdata is sampled, 1..7
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  localparam logic [2:0] LAST_RD = 3'(RD_LATENCY - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] sdata_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        mem_cs_n_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;

  logic        legal_f3_d;
  logic        misaligned_d;
  logic        req_ok_d;
  logic        is_sw_d;

  // Extract the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or halfword of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] sd,
                                              input logic        is_half,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    if (is_half) r[{off[1], 4'b0000} +: 16] = sd;
    else         r[{off, 3'b000} +: 8]      = sd[7:0];
    return r;
  endfunction

  // Legality of the incoming request: funct3 encoding and natural alignment.
  always_comb begin
    legal_f3_d   = 1'b0;
    misaligned_d = 1'b0;
    if (bus.is_store) legal_f3_d = (bus.funct3 inside {F3_B, F3_H, F3_W});
    else              legal_f3_d = (bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (bus.funct3[1:0])
      2'b01:   misaligned_d = bus.addr[0];
      2'b10:   misaligned_d = (bus.addr[1:0] != 2'b00);
      default: misaligned_d = 1'b0;
    endcase
    req_ok_d = legal_f3_d && !misaligned_d;
    is_sw_d  = bus.is_store && (bus.funct3 == F3_W);
  end

  // Request FSM with all outputs registered; SW skips the read phase,
  // errors go straight to DONE without touching memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      sdata_q     <= 16'd0;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_cs_n_q  <= 1'b1;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            is_store_q <= bus.is_store;
            funct3_q   <= bus.funct3;
            off_q      <= bus.addr[1:0];
            sdata_q    <= bus.store_data[15:0];
            mem_addr_q <= {bus.addr[31:2], 2'b00};
            cnt_q      <= 3'd0;
            busy_q     <= 1'b1;
            err_q      <= !req_ok_d;
            if (!req_ok_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (is_sw_d) begin
              state_q     <= WR;
              mem_wr_q    <= 1'b1;
              mem_cs_n_q  <= 1'b0;
              mem_wdata_q <= bus.store_data;
            end else begin
              state_q    <= RD_WAIT;
              mem_rd_q   <= 1'b1;
              mem_cs_n_q <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == LAST_RD) begin
            mem_rd_q <= 1'b0;
            if (is_store_q) begin
              // chip select stays low straight into the write cycle
              state_q     <= WR;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= store_merge(bus.mem_rdata, sdata_q, funct3_q[0], off_q);
            end else begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              mem_cs_n_q  <= 1'b1;
              load_data_q <= load_extend(bus.mem_rdata, funct3_q, off_q);
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WR: begin
          state_q    <= DONE;
          done_q     <= 1'b1;
          mem_wr_q   <= 1'b0;
          mem_cs_n_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.load_data = load_data_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_cs_n  = mem_cs_n_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (RD_LATENCY 1 and 3) receive the
// same request stream; each has its own data_mem model, and a shared
// reference memory predicts loads, store data and timing.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;

  load_store_unit_if if1 ();
  load_store_unit_if if3 ();

  assign if1.req = req;        assign if3.req = req;
  assign if1.is_store = is_store; assign if3.is_store = is_store;
  assign if1.funct3 = funct3;  assign if3.funct3 = funct3;
  assign if1.addr = addr;      assign if3.addr = addr;
  assign if1.store_data = store_data; assign if3.store_data = store_data;

  load_store_unit #(.RD_LATENCY(1)) u_lsu1 (.clk(clk), .rst(rst), .bus(if1.slave));
  load_store_unit #(.RD_LATENCY(3)) u_lsu3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // data_mem models, 64 words, preloadable while rst is held
  logic [31:0] memA [64];
  logic [31:0] memB [64];
  logic [31:0] refmem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'd0;

  assign if1.mem_rdata = memA[if1.mem_addr[7:2]];
  assign if3.mem_rdata = memB[if3.mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      memA[pl_idx] <= pl_data;
      memB[pl_idx] <= pl_data;
    end else begin
      if (if1.mem_wr) memA[if1.mem_addr[7:2]] <= if1.mem_wdata;
      if (if3.mem_wr) memB[if3.mem_addr[7:2]] <= if3.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_exp = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    size = 1 << f3[1:0];
    return (a % 32'(size)) == 32'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int nbits;
    logic [31:0] v, mask;
    nbits = 8 << f3[1:0];
    if (nbits >= 32) return w;
    v    = w >> (8 * (a % 4));
    mask = (32'd1 << nbits) - 32'd1;
    v    = v & mask;
    if (f3 < 3'd4 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] sd);
    int nbits;
    logic [31:0] mask;
    nbits = 8 << f3[1:0];
    if (nbits >= 32) return sd;
    mask = ((32'd1 << nbits) - 32'd1) << (8 * (a % 4));
    return (w & ~mask) | ((sd << (8 * (a % 4))) & mask);
  endfunction

  // ---------------- observation ----------------
  logic        s_rd [2], s_wr [2], s_cs [2], s_busy [2], s_done [2], s_err [2];
  logic [31:0] s_ld [2], s_wd [2], s_wa [2];
  int          obs_done_at [2];
  logic [31:0] obs_wd [2];

  task automatic sample_both();
    s_rd[0] = if1.mem_rd;   s_rd[1] = if3.mem_rd;
    s_wr[0] = if1.mem_wr;   s_wr[1] = if3.mem_wr;
    s_cs[0] = if1.mem_cs_n; s_cs[1] = if3.mem_cs_n;
    s_busy[0] = if1.busy;   s_busy[1] = if3.busy;
    s_done[0] = if1.done;   s_done[1] = if3.done;
    s_err[0] = if1.err;     s_err[1] = if3.err;
    s_ld[0] = if1.load_data; s_ld[1] = if3.load_data;
    s_wd[0] = if1.mem_wdata; s_wd[1] = if3.mem_wdata;
    s_wa[0] = if1.mem_addr;  s_wa[1] = if3.mem_addr;
  endtask

  // One request on both instances; called right after a falling edge.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    logic        legal;
    logic [31:0] w, wexp;
    int          lat [2];
    int          exp_done [2], exp_rd [2];
    int          rdc [2], wrc [2], donec [2], viol [2];
    logic        err_seen [2];
    logic [31:0] wa_seen [2];
    int          win;
    lat[0] = 1; lat[1] = 3;
    legal = ref_legal(st, f3, a);
    w     = refmem[a[7:2]];
    wexp  = (st && legal) ? ref_merge(f3, a, w, sd) : 32'd0;
    for (int k = 0; k < 2; k++) begin
      exp_done[k] = !legal ? 1 : (st && f3 == 3'd2) ? 2 : (!st ? 1 + lat[k] : 2 + lat[k]);
      exp_rd[k]   = (legal && !(st && f3 == 3'd2)) ? lat[k] : 0;
      rdc[k] = 0; wrc[k] = 0; donec[k] = 0; viol[k] = 0;
      err_seen[k] = 1'b0; wa_seen[k] = 32'd0;
      obs_done_at[k] = 0; obs_wd[k] = 32'd0;
    end
    win = exp_done[1] + 2;

    req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      sample_both();
      for (int k = 0; k < 2; k++) begin
        if (s_rd[k]) rdc[k]++;
        if (s_wr[k]) begin wrc[k]++; obs_wd[k] = s_wd[k]; wa_seen[k] = s_wa[k]; end
        if (s_done[k]) begin
          donec[k]++;
          if (obs_done_at[k] == 0) begin obs_done_at[k] = c; err_seen[k] = s_err[k]; end
        end
        if ((s_rd[k] && s_wr[k]) || (s_cs[k] != !(s_rd[k] || s_wr[k]))) viol[k]++;
      end
    end

    if (legal && !st) ld_exp = ref_load(f3, a, w);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("done_cyc L%0d", lat[k]), 32'(obs_done_at[k]), 32'(exp_done[k]));
      check($sformatf("done_cnt L%0d", lat[k]), 32'(donec[k]), 32'd1);
      check($sformatf("err L%0d", lat[k]), 32'(err_seen[k]), 32'(!legal));
      check($sformatf("err_hold L%0d", lat[k]), 32'(s_err[k]), 32'(!legal));
      check($sformatf("rd_cyc L%0d", lat[k]), 32'(rdc[k]), 32'(exp_rd[k]));
      check($sformatf("wr_cyc L%0d", lat[k]), 32'(wrc[k]), 32'(legal && st));
      check($sformatf("proto L%0d", lat[k]), 32'(viol[k]), 32'd0);
      check($sformatf("load_data L%0d", lat[k]), s_ld[k], ld_exp);
      check($sformatf("busy_end L%0d", lat[k]), 32'(s_busy[k]), 32'd0);
      if (legal && st) begin
        check($sformatf("wdata L%0d", lat[k]), obs_wd[k], wexp);
        check($sformatf("waddr L%0d", lat[k]), wa_seen[k], {a[31:2], 2'b00});
      end
    end
    if (legal && st) refmem[a[7:2]] = wexp;
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, sd, v, wexp;
    int          wr1, wr3, dn1, dn3;

    // reset state
    @(negedge clk);
    sample_both();
    for (int k = 0; k < 2; k++) begin
      check("rst_ctl", {26'd0, s_busy[k], s_done[k], s_err[k], s_rd[k], s_wr[k], s_cs[k]}, 32'h1);
      check("rst_addr", s_wa[k], 32'd0);
      check("rst_wdata", s_wd[k], 32'd0);
      check("rst_ld", s_ld[k], 32'd0);
    end

    // preload memories while reset is held
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      if (i == 4) v = 32'h80FF7F01;
      if (i == 8) v = 32'h11223344;
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = v; refmem[i] = v;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // loads from 0x80FF7F01 at 0x10
    run_op(1'b0, 3'd0, 32'h13, 32'd0);
    check("plan_lb13", if1.load_data, 32'hFFFFFF80);
    run_op(1'b0, 3'd4, 32'h13, 32'd0);
    check("plan_lbu13", if1.load_data, 32'h00000080);
    run_op(1'b0, 3'd0, 32'h10, 32'd0);
    check("plan_lb10", if3.load_data, 32'h00000001);
    run_op(1'b0, 3'd1, 32'h12, 32'd0);
    check("plan_lh12", if1.load_data, 32'hFFFF80FF);
    run_op(1'b0, 3'd5, 32'h12, 32'd0);
    check("plan_lhu12", if3.load_data, 32'h000080FF);
    run_op(1'b0, 3'd2, 32'h10, 32'd0);
    check("plan_lw10", if1.load_data, 32'h80FF7F01);
    check("plan_lw_done1", 32'(obs_done_at[0]), 32'd2);
    check("plan_lw_done3", 32'(obs_done_at[1]), 32'd4);

    // sub-word stores into 0x11223344 at 0x20
    run_op(1'b1, 3'd0, 32'h21, 32'hDEADBEAB);
    check("plan_sb_wd", obs_wd[0], 32'h1122AB44);
    check("plan_sb_done1", 32'(obs_done_at[0]), 32'd3);
    check("plan_sb_done3", 32'(obs_done_at[1]), 32'd5);
    run_op(1'b1, 3'd2, 32'h20, 32'h11223344);
    run_op(1'b1, 3'd1, 32'h22, 32'h0000CAFE);
    check("plan_sh_wd", obs_wd[1], 32'hCAFE3344);

    // word store then read back
    run_op(1'b1, 3'd2, 32'h30, 32'hA5A5A5A5);
    check("plan_sw_wd", obs_wd[0], 32'hA5A5A5A5);
    check("plan_sw_done3", 32'(obs_done_at[1]), 32'd2);
    run_op(1'b0, 3'd2, 32'h30, 32'd0);
    check("plan_lw30", if3.load_data, 32'hA5A5A5A5);

    // error cases
    run_op(1'b0, 3'd2, 32'h06, 32'd0);
    run_op(1'b1, 3'd1, 32'h05, 32'h1234);
    run_op(1'b0, 3'd3, 32'h10, 32'd0);
    run_op(1'b1, 3'd4, 32'h20, 32'h5555);
    check("plan_err_ld", if1.load_data, 32'hA5A5A5A5);

    // req held high through SB: re-accept only after each IDLE cycle
    sd   = $urandom;
    wexp = ref_merge(3'd0, 32'h25, refmem[9], sd);
    wr1 = 0; wr3 = 0; dn1 = 0; dn3 = 0;
    req = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h25; store_data = sd;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sample_both();
      check($sformatf("hold_busy1 c%0d", c), 32'(s_busy[0]), 32'((c % 4) != 0));
      check($sformatf("hold_busy3 c%0d", c), 32'(s_busy[1]), 32'((c % 6) != 0));
      if (s_wr[0]) wr1++;
      if (s_wr[1]) wr3++;
      if (s_done[0]) dn1++;
      if (s_done[1]) dn3++;
      if (c == 11) req = 1'b0;
    end
    check("hold_wr1", 32'(wr1), 32'd3);
    check("hold_wr3", 32'(wr3), 32'd2);
    check("hold_done1", 32'(dn1), 32'd3);
    check("hold_done3", 32'(dn3), 32'd2);
    refmem[9] = wexp;

    // asynchronous reset in the middle of a read
    req = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    sample_both();
    check("rdwait_rd1", 32'(s_rd[0]), 32'd1);
    check("rdwait_rd3", 32'(s_rd[1]), 32'd1);
    rst = 1'b1;
    #1;
    sample_both();
    for (int k = 0; k < 2; k++) begin
      check("arst_rd", 32'(s_rd[k]), 32'd0);
      check("arst_csn", 32'(s_cs[k]), 32'd1);
      check("arst_busy", 32'(s_busy[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    ld_exp = 32'd0;
    dn1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sample_both();
      if (s_done[0] || s_done[1] || s_busy[0] || s_busy[1]) dn1++;
    end
    check("arst_quiet", 32'(dn1), 32'd0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      sd = $urandom;
      run_op(st, f3, a, sd);
    end

    // final memory contents
    for (int i = 0; i < 64; i++) begin
      check($sformatf("memA[%0d]", i), memA[i], refmem[i]);
      check($sformatf("memB[%0d]", i), memB[i], refmem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the unpipelined core's execute/writeback logic and data_mem.
- Converts one RISC-V load or store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide data_mem accesses.
- Handles byte lane selection, sign/zero extension and alignment checks.
- Sub-word stores are done as read-modify-write.

Parameters:
- RD_LATENCY, 1: cycles mem_rd is held before mem_rdata is sampled; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  request strobe; sampled only while busy=0
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V funct3 of the load/store
- addr  input  32  effective byte address
- store_data  input  32  rs2 value; low byte or halfword used for SB/SH
- busy  output  1  request in progress
- done  output  1  one-cycle completion pulse
- err  output  1  completion status, valid with done and held until next accept; 1 = misaligned or illegal funct3
- load_data  output  32  extended load result; updated on load completion, held otherwise
- mem_rd  output  1  data_mem read strobe
- mem_wr  output  1  data_mem write strobe
- mem_cs_n  output  1  data_mem chip select, active low
- mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}
- mem_wdata  output  32  data_mem write data
- mem_rdata  input  32  data_mem read data

Behaviour:
- Reset: async and immediate, including mid-operation.
  - State IDLE.
  - busy, done, err, mem_rd, mem_wr = 0; mem_cs_n = 1.
  - mem_addr, mem_wdata, load_data = 0; latency counter = 0.
- All outputs are registered.
- States: IDLE, RD_WAIT, WR, DONE.
- Accept rule: req=1 in IDLE at a rising edge. Capture is_store, funct3, addr[1:0], word address and store_data; busy rises the next cycle.
- req while busy is ignored.
- Legality check at accept:
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Illegal or misaligned: go to DONE with err=1, no memory strobe, load_data unchanged.
- Legal load or SB/SH go to RD_WAIT.
  - mem_cs_n=0 and mem_rd=1 for exactly RD_LATENCY cycles.
  - mem_rdata is sampled at the edge ending the last of those cycles.
- Load completion: RD_WAIT to DONE. load_data is written at that sample edge.
  - LB: sign-extend byte[addr[1:0]].
  - LBU: zero-extend byte[addr[1:0]].
  - LH: sign-extend half[addr[1]].
  - LHU: zero-extend half[addr[1]].
  - LW: the whole word.
- SB/SH: RD_WAIT to WR.
  - Merged word = read word with the addressed byte (store_data[7:0]) or halfword (store_data[15:0]) replaced.
  - All other bytes keep their read value.
- SW: IDLE to WR directly; mem_wdata = store_data.
- WR: mem_cs_n=0, mem_wr=1 for exactly one cycle, then DONE. mem_rd=0 throughout WR.
- DONE: one cycle; done=1, busy=0 next cycle, back to IDLE.
  - A new req may be accepted at the edge ending DONE's following IDLE cycle.
- mem_rd and mem_wr are never asserted together.
- mem_cs_n=1 whenever neither strobe is active.
- Latency, with E0 the accept edge and RD_LATENCY=1:
  - LW: rd in cycle 1, done in cycle 2.
  - SW: wr in cycle 1, done in cycle 2.
  - SB/SH: rd in cycle 1, wr in cycle 2, done in cycle 3.
  - Error: done in cycle 1.
  - Each extra RD_LATENCY cycle adds one cycle to loads and sub-word stores.
- Byte order is little-endian: byte0 = bits[7:0].

Test Plan:
- Word 0x80FF7F01 at 0x10:
  - LB 0x13 -> load_data=0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LB 0x10 -> 0x00000001.
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x12 -> 0x000080FF.
  - LW 0x10 -> 0x80FF7F01.
  - LW: done at cycle 2, err=0.
- Word 0x11223344 at 0x20:
  - SB store_data=0xDEADBEAB, addr 0x21 -> one mem_rd cycle, then one mem_wr cycle with mem_wdata=0x1122AB44, mem_addr=0x20, done at cycle 3.
  - SH store_data=0x0000CAFE, addr 0x22 -> 0xCAFE3344.
- SW 0xA5A5A5A5 at 0x30 -> single wr cycle with that data, no mem_rd, done at cycle 2; then LW 0x30 -> 0xA5A5A5A5.
- Error cases, each giving done at cycle 1, err=1, no mem strobe, mem_cs_n=1, load_data unchanged:
  - LW at 0x06.
  - SH at 0x05.
  - Load funct3=011.
  - Store funct3=100.
- Busy and reset:
  - req asserted throughout a busy SB -> second request not accepted until IDLE.
  - rst pulse during RD_WAIT -> mem_rd=0, mem_cs_n=1, busy=0 immediately; no later done.
- RD_LATENCY=3:
  - LW -> mem_rd high for 3 cycles, done at cycle 4.
  - SB -> wr at cycle 4, done at cycle 5.
